sfifo_ctrl_burst: RTL and testbench

Parameterised synchronous FIFO controller, successor to the single-entry FIFO controller.
- Supports any depth, not only powers of two.
- Supports multi-entry push/pop per cycle and runtime almost-full/almost-empty thresholds.
- Keeps separate write-side (free) and read-side (count) occupancy so that a delayed write commit is handled correctly.
- Reports sticky overflow/underflow errors and provides a synchronous flush.
- Drives address/flag logic for an external dual-port RAM in packet buffers and width-converting queues.

---
 rtl/sfifo_ctrl_burst_pkg.sv | 38 +++
 rtl/sfifo_ctrl_burst_ptr_adv.sv | 26 ++
 rtl/sfifo_ctrl_burst.sv | 148 ++++++++++++++
 tb/tb_sfifo_ctrl_burst.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sfifo_ctrl_burst_pkg.sv
// Shared types and helpers for the burst FIFO controller.
// Provides clog2 for parameter sizing and the registered flag bundle.
package sfifo_ctrl_burst_pkg;

    // Ceiling log2 for sizing; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Status flags registered together from next-state occupancy.
    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
        logic wr_rdy;
        logic rd_rdy;
    } flags_t;

    // Flag values after reset or flush (empty FIFO).
    localparam flags_t FLAGS_RST = '{
        full:   1'b0,
        empty:  1'b1,
        afull:  1'b0,
        aempty: 1'b1,
        wr_rdy: 1'b1,
        rd_rdy: 1'b0
    };

endpackage

// File: rtl/sfifo_ctrl_burst_ptr_adv.sv
// Modular pointer advance: nptr = (ptr + n) mod DEPTH, for any DEPTH.
// Ports: ptr (current pointer), n (advance amount <= DEPTH), nptr (result).
module sfifo_ptr_adv #(
    parameter int DEPTH    = 8,
    parameter int PTR_BITS = 3,
    parameter int N_BITS   = 2
) (
    input  logic [PTR_BITS-1:0] ptr,
    input  logic [N_BITS-1:0]   n,
    output logic [PTR_BITS-1:0] nptr
);

    // One spare bit so ptr + n (< 2*DEPTH) never wraps the adder.
    localparam int SW = ((PTR_BITS > N_BITS) ? PTR_BITS : N_BITS) + 1;

    logic [SW-1:0] sum;
    logic [SW-1:0] sum_wrap;

    assign sum      = SW'(ptr) + SW'(n);
    assign sum_wrap = sum - SW'(DEPTH);

    // ptr < DEPTH and n <= DEPTH, so a single subtract is enough.
    assign nptr = (sum >= SW'(DEPTH)) ? PTR_BITS'(sum_wrap)
                                      : PTR_BITS'(sum);

endmodule

// File: rtl/sfifo_ctrl_burst.sv
// Synchronous multi-entry FIFO controller driving an external dual-port RAM.
// Ports: clk, rstn (sync active-low), flush, wr_n/rd_n (burst sizes),
//   af_lvl/ae_lvl (thresholds), err_clr; outputs wptr/rptr, nwptr/nrptr,
//   count (read side), free (write side), full/empty/afull/aempty,
//   wr_rdy/rd_rdy, sticky ovf/udf.
module sfifo_ctrl_burst
    import sfifo_ctrl_burst_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int MAX_WR         = 2,
    parameter int MAX_RD         = 2,
    parameter int DELAY_WR_COUNT = 0,
    parameter int PTR_BITS       = clog2(DEPTH),
    parameter int CNT_BITS       = clog2(DEPTH + 1),
    parameter int WN_BITS        = clog2(MAX_WR + 1),
    parameter int RN_BITS        = clog2(MAX_RD + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic [WN_BITS-1:0]  wr_n,
    input  logic [RN_BITS-1:0]  rd_n,
    input  logic [CNT_BITS-1:0] af_lvl,
    input  logic [CNT_BITS-1:0] ae_lvl,
    input  logic                err_clr,
    output logic [PTR_BITS-1:0] wptr,
    output logic [PTR_BITS-1:0] rptr,
    output logic [PTR_BITS-1:0] nwptr,
    output logic [PTR_BITS-1:0] nrptr,
    output logic [CNT_BITS-1:0] count,
    output logic [CNT_BITS-1:0] free,
    output logic                full,
    output logic                empty,
    output logic                afull,
    output logic                aempty,
    output logic                wr_rdy,
    output logic                rd_rdy,
    output logic                ovf,
    output logic                udf
);

    // Arithmetic width with one guard bit for add-before-subtract.
    localparam int CW = CNT_BITS + 1;

    logic [WN_BITS-1:0]  wa;
    logic [RN_BITS-1:0]  ra;
    logic [WN_BITS-1:0]  wc;
    logic [WN_BITS-1:0]  wpend;
    logic                wr_ok;
    logic                rd_ok;
    logic                wr_err;
    logic                rd_err;
    logic [CW-1:0]       free_nx;
    logic [CW-1:0]       cnt_nx;
    logic [PTR_BITS-1:0] wadv;
    logic [PTR_BITS-1:0] radv;
    flags_t              flg_q;
    flags_t              flg_nx;

    // Accept checks see only registered occupancy: a same-cycle
    // read cannot make room for a write, and vice versa.
    assign wr_ok  = CW'(wr_n) <= CW'(free);
    assign rd_ok  = CW'(rd_n) <= CW'(count);
    assign wr_err = !flush && !wr_ok;
    assign rd_err = !flush && !rd_ok;
    assign wa     = (!flush && wr_ok) ? wr_n : '0;
    assign ra     = (!flush && rd_ok) ? rd_n : '0;

    // Read side sees writes one cycle late when the RAM needs a
    // cycle to commit the data.
    assign wc = (DELAY_WR_COUNT != 0) ? wpend : wa;

    assign free_nx = CW'(free) - CW'(wa) + CW'(ra);
    assign cnt_nx  = CW'(count) + CW'(wc) - CW'(ra);

    sfifo_ptr_adv #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS),
        .N_BITS   (WN_BITS)
    ) u_wadv (
        .ptr  (wptr),
        .n    (wa),
        .nptr (wadv)
    );

    sfifo_ptr_adv #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS),
        .N_BITS   (RN_BITS)
    ) u_radv (
        .ptr  (rptr),
        .n    (ra),
        .nptr (radv)
    );

    assign nwptr = flush ? '0 : wadv;
    assign nrptr = flush ? '0 : radv;

    always_comb begin
        flg_nx        = FLAGS_RST;
        flg_nx.full   = (free_nx == '0);
        flg_nx.empty  = (cnt_nx == '0);
        flg_nx.afull  = (free_nx <= CW'(af_lvl));
        flg_nx.aempty = (cnt_nx <= CW'(ae_lvl));
        flg_nx.wr_rdy = (free_nx >= CW'(MAX_WR));
        flg_nx.rd_rdy = (cnt_nx >= CW'(MAX_RD));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            free  <= CNT_BITS'(DEPTH);
            wpend <= '0;
            flg_q <= FLAGS_RST;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            // New errors win over a same-cycle clear.
            ovf <= wr_err | (ovf & ~err_clr);
            udf <= rd_err | (udf & ~err_clr);
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
                free  <= CNT_BITS'(DEPTH);
                wpend <= '0;
                flg_q <= FLAGS_RST;
            end else begin
                wptr  <= wadv;
                rptr  <= radv;
                count <= cnt_nx[CNT_BITS-1:0];
                free  <= free_nx[CNT_BITS-1:0];
                wpend <= wa;
                flg_q <= flg_nx;
            end
        end
    end

    assign full   = flg_q.full;
    assign empty  = flg_q.empty;
    assign afull  = flg_q.afull;
    assign aempty = flg_q.aempty;
    assign wr_rdy = flg_q.wr_rdy;
    assign rd_rdy = flg_q.rd_rdy;

endmodule

// File: tb/tb_sfifo_ctrl_burst.sv
// Bench for sfifo_ctrl_burst: DEPTH=6, MAX_WR=MAX_RD=2, one instance
// with immediate write commit and one with delayed commit.
module tb_sfifo_ctrl_burst;

    typedef struct packed {
        logic [2:0] w;
        logic [2:0] r;
        logic [2:0] c;
        logic [2:0] f;
        logic [7:0] fl;
    } out_t;

    typedef struct {
        logic       rstn;
        logic       flush;
        logic [1:0] wr;
        logic [1:0] rd;
        logic       clr;
        out_t       e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn0 = 1'b0, flush0 = 1'b0, clr0 = 1'b0;
    logic [1:0] wr0 = '0, rd0 = '0;
    logic       rstn1 = 1'b0, flush1 = 1'b0, clr1 = 1'b0;
    logic [1:0] wr1 = '0, rd1 = '0;
    logic [2:0] af = 3'd2, ae = 3'd1;

    logic [2:0] wp0, rp0, nwp0, nrp0, cnt0, fr0;
    logic       full0, emp0, af0, ae0, wrr0, rdr0, ovf0, udf0;
    logic [2:0] wp1, rp1, nwp1, nrp1, cnt1, fr1;
    logic       full1, emp1, af1, ae1, wrr1, rdr1, ovf1, udf1;

    sfifo_ctrl_burst #(
        .DEPTH(6), .MAX_WR(2), .MAX_RD(2), .DELAY_WR_COUNT(0)
    ) u0 (
        .clk(clk), .rstn(rstn0), .flush(flush0),
        .wr_n(wr0), .rd_n(rd0), .af_lvl(af), .ae_lvl(ae),
        .err_clr(clr0), .wptr(wp0), .rptr(rp0),
        .nwptr(nwp0), .nrptr(nrp0), .count(cnt0), .free(fr0),
        .full(full0), .empty(emp0), .afull(af0), .aempty(ae0),
        .wr_rdy(wrr0), .rd_rdy(rdr0), .ovf(ovf0), .udf(udf0)
    );

    sfifo_ctrl_burst #(
        .DEPTH(6), .MAX_WR(2), .MAX_RD(2), .DELAY_WR_COUNT(1)
    ) u1 (
        .clk(clk), .rstn(rstn1), .flush(flush1),
        .wr_n(wr1), .rd_n(rd1), .af_lvl(af), .ae_lvl(ae),
        .err_clr(clr1), .wptr(wp1), .rptr(rp1),
        .nwptr(nwp1), .nrptr(nrp1), .count(cnt1), .free(fr1),
        .full(full1), .empty(emp1), .afull(af1), .aempty(ae1),
        .wr_rdy(wrr1), .rd_rdy(rdr1), .ovf(ovf1), .udf(udf1)
    );

    int   errors = 0;
    int   checks = 0;
    out_t exp_q[$];

    // Flag byte order: full empty afull aempty wr_rdy rd_rdy ovf udf
    function automatic out_t o(int w, int r, int c, int f,
                               logic [7:0] fl);
        out_t x;
        x.w  = 3'(w);
        x.r  = 3'(r);
        x.c  = 3'(c);
        x.f  = 3'(f);
        x.fl = fl;
        return x;
    endfunction

    function automatic vec_t v(logic rs, logic fls, int wr, int rd,
                               logic clr, out_t e);
        vec_t x;
        x.rstn  = rs;
        x.flush = fls;
        x.wr    = 2'(wr);
        x.rd    = 2'(rd);
        x.clr   = clr;
        x.e     = e;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic apply(input int d, input vec_t x, input string nm);
        out_t act;
        out_t e;
        @(negedge clk);
        if (d == 0) begin
            rstn0 = x.rstn; flush0 = x.flush;
            wr0 = x.wr; rd0 = x.rd; clr0 = x.clr;
        end else begin
            rstn1 = x.rstn; flush1 = x.flush;
            wr1 = x.wr; rd1 = x.rd; clr1 = x.clr;
        end
        exp_q.push_back(x.e);
        #1;
        if (x.rstn) begin
            if (d == 0) begin
                chk({nm, " nwptr"}, 32'(nwp0), 32'(x.e.w));
                chk({nm, " nrptr"}, 32'(nrp0), 32'(x.e.r));
            end else begin
                chk({nm, " nwptr"}, 32'(nwp1), 32'(x.e.w));
                chk({nm, " nrptr"}, 32'(nrp1), 32'(x.e.r));
            end
        end
        @(posedge clk);
        #1;
        if (d == 0)
            act = {wp0, rp0, cnt0, fr0,
                   full0, emp0, af0, ae0, wrr0, rdr0, ovf0, udf0};
        else
            act = {wp1, rp1, cnt1, fr1,
                   full1, emp1, af1, ae1, wrr1, rdr1, ovf1, udf1};
        e = exp_q.pop_front();
        chk({nm, " state"}, 32'(act), 32'(e));
        if (d == 0)
            chk({nm, " count+free"}, 32'(cnt0) + 32'(fr0), 32'd6);
    endtask

    vec_t t0[25];
    vec_t t1[11];

    initial begin
        // Immediate-commit instance
        t0[0]  = v(0, 0, 0, 0, 0, o(0, 0, 0, 6, 8'b01011000));
        t0[1]  = v(1, 0, 2, 0, 0, o(2, 0, 2, 4, 8'b00001100));
        t0[2]  = v(1, 0, 2, 0, 0, o(4, 0, 4, 2, 8'b00101100));
        t0[3]  = v(1, 0, 2, 0, 0, o(0, 0, 6, 0, 8'b10100100));
        t0[4]  = v(1, 0, 1, 0, 0, o(0, 0, 6, 0, 8'b10100110));
        t0[5]  = v(1, 0, 0, 2, 1, o(0, 2, 4, 2, 8'b00101100));
        t0[6]  = v(1, 0, 2, 2, 0, o(2, 4, 4, 2, 8'b00101100));
        t0[7]  = v(1, 0, 2, 2, 0, o(4, 0, 4, 2, 8'b00101100));
        t0[8]  = v(1, 0, 2, 2, 0, o(0, 2, 4, 2, 8'b00101100));
        t0[9]  = v(1, 0, 0, 2, 0, o(0, 4, 2, 4, 8'b00001100));
        t0[10] = v(1, 0, 0, 1, 0, o(0, 5, 1, 5, 8'b00011000));
        t0[11] = v(1, 0, 0, 1, 0, o(0, 0, 0, 6, 8'b01011000));
        t0[12] = v(1, 0, 2, 1, 0, o(2, 0, 2, 4, 8'b00001101));
        t0[13] = v(1, 0, 2, 0, 0, o(4, 0, 4, 2, 8'b00101101));
        t0[14] = v(1, 0, 2, 0, 0, o(0, 0, 6, 0, 8'b10100101));
        t0[15] = v(1, 0, 0, 1, 0, o(0, 1, 5, 1, 8'b00100101));
        t0[16] = v(1, 0, 2, 0, 1, o(0, 1, 5, 1, 8'b00100110));
        t0[17] = v(1, 1, 2, 1, 0, o(0, 0, 0, 6, 8'b01011010));
        t0[18] = v(1, 0, 1, 0, 1, o(1, 0, 1, 5, 8'b00011000));
        t0[19] = v(1, 0, 2, 0, 0, o(3, 0, 3, 3, 8'b00001100));
        t0[20] = v(1, 0, 2, 0, 0, o(5, 0, 5, 1, 8'b00100100));
        t0[21] = v(1, 0, 0, 2, 0, o(5, 2, 3, 3, 8'b00001100));
        t0[22] = v(1, 0, 2, 0, 0, o(1, 2, 5, 1, 8'b00100100));
        t0[23] = v(0, 0, 2, 2, 0, o(0, 0, 0, 6, 8'b01011000));
        t0[24] = v(1, 0, 1, 0, 0, o(1, 0, 1, 5, 8'b00011000));
        // Delayed-commit instance
        t1[0]  = v(0, 0, 0, 0, 0, o(0, 0, 0, 6, 8'b01011000));
        t1[1]  = v(1, 0, 2, 0, 0, o(2, 0, 0, 4, 8'b01011000));
        t1[2]  = v(1, 0, 0, 0, 0, o(2, 0, 2, 4, 8'b00001100));
        t1[3]  = v(1, 0, 2, 0, 0, o(4, 0, 2, 2, 8'b00101100));
        t1[4]  = v(1, 0, 2, 0, 0, o(0, 0, 4, 0, 8'b10100100));
        t1[5]  = v(1, 0, 1, 0, 0, o(0, 0, 6, 0, 8'b10100110));
        t1[6]  = v(1, 0, 0, 1, 0, o(0, 1, 5, 1, 8'b00100110));
        t1[7]  = v(1, 0, 1, 0, 0, o(1, 1, 5, 0, 8'b10100110));
        t1[8]  = v(1, 1, 0, 0, 0, o(0, 0, 0, 6, 8'b01011010));
        t1[9]  = v(1, 0, 0, 0, 0, o(0, 0, 0, 6, 8'b01011010));
        t1[10] = v(1, 0, 0, 1, 0, o(0, 0, 0, 6, 8'b01011011));

        for (int i = 0; i < 25; i++)
            apply(0, t0[i], $sformatf("u0[%0d]", i));
        @(negedge clk);
        wr0 = '0; rd0 = '0; clr0 = 1'b0; flush0 = 1'b0;
        for (int i = 0; i < 11; i++)
            apply(1, t1[i], $sformatf("u1[%0d]", i));

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
